// File: rtl/vec_unit_v2.sv
// vec_unit_v2: multi-beat vector ALU with an internal register file.
// Commands are latched on accept, then executed lanes_p elements per beat;
// results are held in DONE until the consumer takes them with yumi_i.

// One element-wise ALU slice: add/sub/mul/max against either B or the scalar.
module vec_unit_v2_lane #(
  parameter int vdw_p = 8
) (
  input  logic [2:0]       op_i,
  input  logic [vdw_p-1:0] a_i,
  input  logic [vdw_p-1:0] b_i,
  input  logic [vdw_p-1:0] s_i,
  output logic [vdw_p-1:0] res_o
);
  logic [vdw_p-1:0] opnd;

  // op[2] picks the scalar as second operand, op[1:0] picks the function
  always_comb begin
    opnd = op_i[2] ? s_i : b_i;
    unique case (op_i[1:0])
      2'd0:    res_o = a_i + opnd;
      2'd1:    res_o = a_i - opnd;
      2'd2:    res_o = a_i * opnd;
      default: res_o = (a_i > opnd) ? a_i : opnd;
    endcase
  end
endmodule

module vec_unit_v2 #(
  parameter  int els_p     = 32,
  parameter  int vlen_p    = 16,
  parameter  int vdw_p     = 8,
  parameter  int lanes_p   = 4,
  localparam int beats_lp  = vlen_p / lanes_p,
  localparam int addr_w_lp = $clog2(els_p),
  localparam int red_w_lp  = vdw_p + $clog2(vlen_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [3:0]              op_i,
  input  logic [addr_w_lp-1:0]    addr_a_i,
  input  logic [addr_w_lp-1:0]    addr_b_i,
  input  logic [addr_w_lp-1:0]    addr_c_i,
  input  logic [vdw_p-1:0]        scalar_i,
  input  logic [vlen_p*vdw_p-1:0] w_data_i,
  output logic                    v_o,
  input  logic                    yumi_i,
  output logic [vlen_p*vdw_p-1:0] r_data_o,
  output logic [red_w_lp-1:0]     red_o,
  output logic                    err_o
);
  localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int el_w_lp   = (vlen_p > 1) ? $clog2(vlen_p) : 1;

  localparam logic [3:0] OP_READ  = 4'b1000;
  localparam logic [3:0] OP_WRITE = 4'b1001;
  localparam logic [3:0] OP_RED   = 4'b1010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e                                      state_q, state_d;
  logic [beat_w_lp-1:0]                        beat_q, beat_d;
  logic [3:0]                                  op_q, op_d;
  logic [addr_w_lp-1:0]                        a_q, a_d, b_q, b_d, c_q, c_d;
  logic [vdw_p-1:0]                            s_q, s_d;
  logic [vlen_p-1:0][vdw_p-1:0]                wd_q, wd_d;
  logic [els_p-1:0][vlen_p-1:0][vdw_p-1:0]     vrf_q, vrf_d;
  logic [vlen_p-1:0][vdw_p-1:0]                r_q, r_d;
  logic [red_w_lp-1:0]                         red_q, red_d;
  logic                                        err_q, err_d, v_q, v_d;

  logic [lanes_p-1:0][el_w_lp-1:0]             eidx;
  logic [lanes_p-1:0][vdw_p-1:0]               a_el, b_el, wd_el, alu_el;
  logic [red_w_lp-1:0]                         lane_sum;

  assign ready_o  = (state_q == IDLE);
  assign v_o      = v_q;
  assign err_o    = err_q;
  assign red_o    = red_q;
  assign r_data_o = r_q;

  // Element indices and operand fetch for the current beat
  always_comb begin
    for (int l = 0; l < lanes_p; l++) begin
      eidx[l]  = el_w_lp'(int'(beat_q) * lanes_p + l);
      a_el[l]  = vrf_q[a_q][eidx[l]];
      b_el[l]  = vrf_q[b_q][eidx[l]];
      wd_el[l] = wd_q[eidx[l]];
    end
  end

  for (genvar g = 0; g < lanes_p; g++) begin : g_lane
    vec_unit_v2_lane #(.vdw_p(vdw_p)) u_lane (
      .op_i (op_q[2:0]),
      .a_i  (a_el[g]),
      .b_i  (b_el[g]),
      .s_i  (s_q),
      .res_o(alu_el[g])
    );
  end

  // Next-state: command latch, beat sequencing, VRF write-back, result capture
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    s_d      = s_q;
    wd_d     = wd_q;
    vrf_d    = vrf_q;
    r_d      = r_q;
    red_d    = red_q;
    err_d    = err_q;
    lane_sum = '0;
    for (int l = 0; l < lanes_p; l++) lane_sum = lane_sum + red_w_lp'(a_el[l]);

    unique case (state_q)
      IDLE: if (v_i) begin
        op_d = op_i;
        a_d  = addr_a_i;
        b_d  = addr_b_i;
        c_d  = addr_c_i;
        s_d  = scalar_i;
        wd_d = w_data_i;
        if (op_i > OP_RED) begin
          // illegal ops never touch the VRF, so they skip EXEC entirely
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          err_d   = 1'b0;
          beat_d  = '0;
          state_d = EXEC;
          if (op_i == OP_RED) red_d = '0;
        end
      end
      EXEC: begin
        // each element is read and written in the same beat, so C may alias A/B
        for (int l = 0; l < lanes_p; l++) begin
          case (op_q)
            OP_READ:  r_d[eidx[l]] = a_el[l];
            OP_WRITE: vrf_d[c_q][eidx[l]] = wd_el[l];
            OP_RED:   ;
            default:  vrf_d[c_q][eidx[l]] = alu_el[l];
          endcase
        end
        if (op_q == OP_RED) red_d = red_q + lane_sum;
        if (beat_q == beat_w_lp'(beats_lp - 1)) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: if (yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    v_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      wd_q    <= '0;
      vrf_q   <= '0;
      r_q     <= '0;
      red_q   <= '0;
      err_q   <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      s_q     <= s_d;
      wd_q    <= wd_d;
      vrf_q   <= vrf_d;
      r_q     <= r_d;
      red_q   <= red_d;
      err_q   <= err_d;
      v_q     <= v_d;
    end
  end
endmodule

// File: tb/tb_vec_unit_v2.sv
// Bench for vec_unit_v2: directed vector table, backpressure/illegal/reset
// sequences, then random commands against an array-based reference model.
module tb_vec_unit_v2;
  localparam int AW = 5;
  localparam int DW = 128;
  localparam int RW = 12;

  logic          clk = 1'b0;
  logic          reset_n, v_i, yumi_i;
  logic [3:0]    op_i;
  logic [AW-1:0] addr_a_i, addr_b_i, addr_c_i;
  logic [7:0]    scalar_i;
  logic [DW-1:0] w_data_i;
  logic          ready_o, v_o, err_o;
  logic [DW-1:0] r_data_o;
  logic [RW-1:0] red_o;

  always #5 clk = ~clk;

  vec_unit_v2 dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .addr_a_i(addr_a_i), .addr_b_i(addr_b_i), .addr_c_i(addr_c_i),
    .scalar_i(scalar_i), .w_data_i(w_data_i), .v_o(v_o), .yumi_i(yumi_i),
    .r_data_o(r_data_o), .red_o(red_o), .err_o(err_o)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // reference model: whole-vector semantics on plain ints
  int          mem[32][16];
  logic [DW-1:0] exp_r;
  logic [RW-1:0] exp_red;
  logic        exp_err;

  task automatic model_reset();
    foreach (mem[i, k]) mem[i][k] = 0;
    exp_r = '0; exp_red = '0; exp_err = 1'b0;
  endtask

  task automatic model(input logic [3:0] op, input int a, b, c, input logic [7:0] s,
                       input logic [DW-1:0] wd, output int lat);
    int res[16];
    int ea, eo, sum;
    if (op > 4'd10) begin exp_err = 1'b1; lat = 1; return; end
    exp_err = 1'b0;
    lat = 5;
    if (op == 4'd10) begin
      sum = 0;
      for (int k = 0; k < 16; k++) sum += mem[a][k];
      exp_red = RW'(sum);
      return;
    end
    if (op == 4'd8) begin
      for (int k = 0; k < 16; k++) exp_r[k*8 +: 8] = 8'(mem[a][k]);
      return;
    end
    for (int k = 0; k < 16; k++) begin
      ea = mem[a][k];
      eo = (op < 4'd4) ? mem[b][k] : int'(s);
      case (op[1:0])
        2'd0: res[k] = ea + eo;
        2'd1: res[k] = ea - eo;
        2'd2: res[k] = ea * eo;
        default: res[k] = (ea > eo) ? ea : eo;
      endcase
      if (op == 4'd9) res[k] = int'(wd[k*8 +: 8]);
    end
    for (int k = 0; k < 16; k++) mem[c][k] = res[k] & 255;
  endtask

  // One full command: accept, wait for v_o, optional backpressure, consume
  task automatic cmd(input logic [3:0] op, input int a, b, c, input logic [7:0] s,
                     input logic [DW-1:0] wd, input int hold, output int lat,
                     output logic e, output logic [DW-1:0] r, output logic [RW-1:0] rd);
    int n = 0;
    int mlat;
    while (!ready_o && n < 100) begin @(negedge clk); n++; end
    if (!ready_o) chk("ready_wait", {159'd0, ready_o}, 160'd1);
    v_i = 1'b1; op_i = op; scalar_i = s; w_data_i = wd;
    addr_a_i = AW'(a); addr_b_i = AW'(b); addr_c_i = AW'(c);
    @(negedge clk);
    // scramble inputs after accept: the DUT must use its latched copy
    v_i = 1'b0; op_i = 4'($urandom); scalar_i = 8'($urandom);
    w_data_i = {$urandom, $urandom, $urandom, $urandom};
    addr_a_i = AW'($urandom); addr_b_i = AW'($urandom); addr_c_i = AW'($urandom);
    lat = 1;
    while (!v_o && lat < 50) begin @(negedge clk); lat++; end
    e = err_o; r = r_data_o; rd = red_o;
    for (int h = 0; h < hold; h++) begin
      v_i = 1'b1; op_i = 4'd9; addr_c_i = AW'(a);
      @(negedge clk);
      chk("hold_stable", {16'd0, ready_o, v_o, err_o, red_o, r_data_o},
          {16'd0, 1'b0, 1'b1, e, rd, r});
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    chk("post_yumi", {158'd0, ready_o, v_o}, {158'd0, 1'b1, 1'b0});
    model(op, a, b, c, s, wd, mlat);
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] v);
    logic [DW-1:0] x;
    for (int k = 0; k < 16; k++) x[k*8 +: 8] = v;
    return x;
  endfunction

  typedef struct {
    string         nm;
    logic [3:0]    op;
    int            a, b, c;
    logic [7:0]    s;
    logic [DW-1:0] wd;
    int            hold;
    int            lat;
    logic          err;
    bit            chk_r;
    logic [DW-1:0] r;
    bit            chk_red;
    logic [RW-1:0] red;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [3:0] op, input int a, b, c,
                     input logic [7:0] s, input logic [DW-1:0] wd, input int hold,
                     input int lat, input logic err, input bit chk_r,
                     input logic [DW-1:0] r, input bit chk_red, input logic [RW-1:0] red);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.c = c; v.s = s; v.wd = wd;
    v.hold = hold; v.lat = lat; v.err = err; v.chk_r = chk_r; v.r = r;
    v.chk_red = chk_red; v.red = red;
    vecs.push_back(v);
  endtask

  initial begin
    logic [DW-1:0] ramp, r;
    logic [RW-1:0] rd;
    logic e;
    int lat, mlat, a, b, c;
    logic [3:0] op;
    logic [7:0] s;
    logic [DW-1:0] wd;

    reset_n = 1'b0; v_i = 1'b0; yumi_i = 1'b0; op_i = '0; scalar_i = '0; w_data_i = '0;
    addr_a_i = '0; addr_b_i = '0; addr_c_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {15'd0, ready_o, v_o, err_o, red_o, r_data_o},
        {15'd0, 1'b1, 1'b0, 1'b0, 12'd0, 128'd0});

    for (int k = 0; k < 16; k++) ramp[k*8 +: 8] = 8'(k);

    add("wr3",     4'd9,  0, 0, 3, 8'd0,  ramp,       0, 5, 0, 1, 128'd0,     0, 12'd0);
    add("rd3",     4'd8,  3, 0, 0, 8'd0,  '0,         0, 5, 0, 1, ramp,       0, 12'd0);
    add("wr1",     4'd9,  0, 0, 1, 8'd0,  rep(8'hF0), 0, 5, 0, 0, '0,         0, 12'd0);
    add("wr2",     4'd9,  0, 0, 2, 8'd0,  rep(8'h20), 0, 5, 0, 0, '0,         0, 12'd0);
    add("add",     4'd0,  1, 2, 4, 8'd0,  '0,         0, 5, 0, 0, '0,         0, 12'd0);
    add("rd_add",  4'd8,  4, 0, 0, 8'd0,  '0,         0, 5, 0, 1, rep(8'h10), 0, 12'd0);
    add("mul",     4'd2,  1, 2, 4, 8'd0,  '0,         0, 5, 0, 0, '0,         0, 12'd0);
    add("rd_mul",  4'd8,  4, 0, 0, 8'd0,  '0,         0, 5, 0, 1, rep(8'h00), 0, 12'd0);
    add("sub",     4'd1,  2, 1, 4, 8'd0,  '0,         0, 5, 0, 0, '0,         0, 12'd0);
    add("rd_sub",  4'd8,  4, 0, 0, 8'd0,  '0,         0, 5, 0, 1, rep(8'h30), 0, 12'd0);
    add("wr5",     4'd9,  0, 0, 5, 8'd0,  rep(8'h07), 0, 5, 0, 0, '0,         0, 12'd0);
    add("adds",    4'd4,  5, 0, 5, 8'd3,  '0,         0, 5, 0, 0, '0,         0, 12'd0);
    add("rd_adds", 4'd8,  5, 0, 0, 8'd0,  '0,         0, 5, 0, 1, rep(8'h0A), 0, 12'd0);
    add("maxs",    4'd7,  5, 0, 5, 8'd12, '0,         0, 5, 0, 0, '0,         0, 12'd0);
    add("rd_maxs", 4'd8,  5, 0, 0, 8'd0,  '0,         0, 5, 0, 1, rep(8'h0C), 0, 12'd0);
    add("wr6",     4'd9,  0, 0, 6, 8'd0,  rep(8'hFF), 0, 5, 0, 0, '0,         0, 12'd0);
    add("reduce",  4'd10, 6, 0, 6, 8'd0,  '0,         0, 5, 0, 1, rep(8'h0C), 1, 12'd4080);
    add("rd6_bp",  4'd8,  6, 0, 0, 8'd0,  '0,        10, 5, 0, 1, rep(8'hFF), 1, 12'd4080);
    add("illegal", 4'd15, 6, 6, 6, 8'd1,  '0,         0, 1, 1, 1, rep(8'hFF), 1, 12'd4080);
    add("rd6_post",4'd8,  6, 0, 0, 8'd0,  '0,         0, 5, 0, 1, rep(8'hFF), 0, 12'd0);

    foreach (vecs[i]) begin
      cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].wd,
          vecs[i].hold, lat, e, r, rd);
      chk({vecs[i].nm, "_lat"}, 160'(lat), 160'(vecs[i].lat));
      chk({vecs[i].nm, "_err"}, {159'd0, e}, {159'd0, vecs[i].err});
      if (vecs[i].chk_r)   chk({vecs[i].nm, "_rdata"}, {32'd0, r}, {32'd0, vecs[i].r});
      if (vecs[i].chk_red) chk({vecs[i].nm, "_red"}, {148'd0, rd}, {148'd0, vecs[i].red});
    end

    // reset in the middle of EXEC: command aborted, VRF cleared
    v_i = 1'b1; op_i = 4'd0; addr_a_i = 5'd1; addr_b_i = 5'd2; addr_c_i = 5'd3;
    @(negedge clk);
    v_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_exec", {158'd0, v_o, ready_o}, {158'd0, 1'b0, 1'b1});
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {15'd0, ready_o, v_o, err_o, red_o, r_data_o},
        {15'd0, 1'b1, 1'b0, 1'b0, 12'd0, 128'd0});
    model_reset();
    cmd(4'd8, 1, 0, 0, 8'd0, '0, 0, lat, e, r, rd);
    chk("rst_rd1", {32'd0, r}, {32'd0, exp_r});
    cmd(4'd8, 3, 0, 0, 8'd0, '0, 0, lat, e, r, rd);
    chk("rst_rd3", {32'd0, r}, 160'd0);

    // random commands against the reference model
    for (int i = 0; i < 60; i++) begin
      op = (i < 8) ? 4'd9 : 4'($urandom_range(0, 12));
      if (op > 4'd10) op = 4'($urandom_range(11, 15));
      a = $urandom_range(0, 7); b = $urandom_range(0, 7); c = $urandom_range(0, 7);
      if (i < 8) c = i;
      s = 8'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      cmd(op, a, b, c, s, wd, $urandom_range(0, 2), lat, e, r, rd);
      mlat = (op > 4'd10) ? 1 : 5;
      chk("rnd_lat", 160'(lat), 160'(mlat));
      chk("rnd_out", {19'd0, e, rd, r}, {19'd0, exp_err, exp_red, exp_r});
    end
    // final sweep: every touched register read back and compared
    for (int i = 0; i < 8; i++) begin
      cmd(4'd8, i, 0, 0, 8'd0, '0, 0, lat, e, r, rd);
      chk("sweep_rd", {32'd0, r}, {32'd0, exp_r});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
